// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions (frame states, legal limits, line levels) for TX and RX
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_parity_gen.sv
// rtl/uart_parity_gen.sv - combinational even/odd parity bit over a data word
module uart_parity_gen #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  odd_i,
    output logic                  parity_o
);

    always_comb begin
        parity_o = (^data_i) ^ odd_i;
    end

endmodule

// File: rtl/uart_tx_frame_ser.sv
// rtl/uart_tx_frame_ser.sv - UART TX frame FSM + serializer; optional parity bit under UART_TX_PARITY_EN
module uart_tx_frame_ser
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tick,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic                            par_odd,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(DATA_WIDTH+1)-1:0] bit_cnt
);

    localparam int              CW        = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DATA_WIDTH);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_cfg_check
        $error("uart_tx_frame_ser: DATA_WIDTH or STOP_BITS out of range");
    end

    uart_state_e           state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  stop_q, stop_d;
    logic                  last_stop;
    logic                  accept;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d, par_new;

    // Parity is taken from the accepted word, never from the draining shift register.
    uart_parity_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_gen (
        .data_i  (s_data),
        .odd_i   (par_odd),
        .parity_o(par_new)
    );
`else
    logic unused_par_odd;
    assign unused_par_odd = par_odd;
`endif

    assign last_stop = (state_q == ST_STOP) && (stop_q == STOP_LAST);
    assign s_ready   = tick && ((state_q == ST_IDLE) || last_stop);
    assign accept    = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            stop_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            stop_q  <= stop_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Accept is only possible in IDLE or on the last stop bit, so it always restarts a frame.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_START;
        end else if (tick) begin
            case (state_q)
                ST_START: state_d = ST_DATA;
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: state_d = ST_STOP;
`endif
                ST_STOP: begin
                    if (last_stop) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_d    = tx_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        stop_d  = stop_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            shift_d = s_data;
            cnt_d   = '0;
            busy_d  = 1'b1;
            tx_d    = ~IDLE_LEVEL;
            stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = par_new;
`endif
        end else if (tick) begin
            case (state_q)
                ST_START: begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = CW'(1);
                end
                ST_DATA: begin
                    if (cnt_q != CNT_LAST) begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d   = par_q;
`else
                        tx_d   = IDLE_LEVEL;
`endif
                        stop_d = 1'b0;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    tx_d   = IDLE_LEVEL;
                    stop_d = 1'b0;
                end
`endif
                ST_STOP: begin
                    if (last_stop) begin
                        tx_d   = IDLE_LEVEL;
                        busy_d = 1'b0;
                        cnt_d  = '0;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
                default: begin
                    tx_d = IDLE_LEVEL;
                end
            endcase
        end
    end

    always_comb begin
        tx      = tx_q;
        busy    = busy_q;
        bit_cnt = cnt_q;
    end

endmodule
